reg_file_wb: RTL and testbench

Writeback register and 16×16-bit register file with a hazard scoreboard for the 16-bit MIPS datapath. The block sits directly downstream of the destination-register mux. It latches the selected 4-bit destination together with the result data and write enable into a writeback stage, then commits the value to the register file one cycle later. It also serves two combinational read ports to decode and tracks in-flight destinations so that decode can stall on RAW and WAW hazards.

---
 rtl/mips16_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 59 +++++
 rtl/reg_file_wb.sv | 97 +++++++++
 tb/tb_reg_file_wb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS datapath.
// Build option REG_FILE_WB_BYPASS_EN enables writeback-to-read forwarding.
package mips16_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned DATA_W    = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 4'd0;

`ifdef REG_FILE_WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-register scoreboard and RAW/WAW stall generation for decode.
// With REG_FILE_WB_BYPASS_EN the committing register does not raise a RAW hazard.
module reg_scoreboard
    import mips16_pkg::*;
#(
    parameter int unsigned NREGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_v_i,
    input  reg_idx_t         commit_idx_i,
    input  reg_idx_t         rs_addr_i,
    input  reg_idx_t         rt_addr_i,
    input  logic             issue_valid_i,
    input  logic             issue_wr_i,
    input  reg_idx_t         issue_dest_i,
    output logic             stall_o,
    output logic [NREGS-1:0] busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             hz_rs;
    logic             hz_rt;
    logic             waw;
    logic             issue_set;

    always_comb begin
        hz_rs = busy_q[rs_addr_i] &&
                !(BYPASS_EN && commit_v_i && (commit_idx_i == rs_addr_i));
        hz_rt = busy_q[rt_addr_i] &&
                !(BYPASS_EN && commit_v_i && (commit_idx_i == rt_addr_i));
        waw   = issue_wr_i && busy_q[issue_dest_i];

        stall_o   = issue_valid_i && (hz_rs || hz_rt || waw);
        issue_set = issue_valid_i && issue_wr_i && !stall_o &&
                    (issue_dest_i != REG_ZERO);

        // Set is applied after clear so a new producer keeps ownership.
        busy_d = busy_q;
        if (commit_v_i) begin
            busy_d[commit_idx_i] = 1'b0;
        end
        if (issue_set) begin
            busy_d[issue_dest_i] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_wb.sv
// Writeback stage, 16x16 register file with R0 hardwired to zero, and hazard scoreboard.
// With REG_FILE_WB_BYPASS_EN the pending writeback is forwarded to both read ports.
module reg_file_wb
    import mips16_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = DATA_W
) (
    input  logic             clock,
    input  logic             reset,
    input  reg_idx_t         Dest,
    input  logic             RegWrite,
    input  logic [DW-1:0]    wb_data,
    input  reg_idx_t         rs_addr,
    input  reg_idx_t         rt_addr,
    output logic [DW-1:0]    rs_data,
    output logic [DW-1:0]    rt_data,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  reg_idx_t         issue_dest,
    output logic             stall,
    output logic [NREGS-1:0] busy
);

    logic          wb_v_q;
    logic          wb_v_d;
    reg_idx_t      wb_dst_q;
    reg_idx_t      wb_dst_d;
    logic [DW-1:0] wb_d_q;
    logic [DW-1:0] wb_d_d;

    logic [DW-1:0] regs_q [NREGS];

    // Writes to R0 are dropped here, so the array entry for R0 never changes.
    always_comb begin
        wb_v_d   = RegWrite && (Dest != REG_ZERO);
        wb_dst_d = Dest;
        wb_d_d   = wb_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_v_q   <= 1'b0;
            wb_dst_q <= REG_ZERO;
            wb_d_q   <= '0;
        end else begin
            wb_v_q   <= wb_v_d;
            wb_dst_q <= wb_dst_d;
            wb_d_q   <= wb_d_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_v_q) begin
            regs_q[wb_dst_q] <= wb_d_q;
        end
    end

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (BYPASS_EN && wb_v_q && (wb_dst_q == rs_addr)) begin
            rs_data = wb_d_q;
        end
        if (rs_addr == REG_ZERO) begin
            rs_data = '0;
        end

        rt_data = regs_q[rt_addr];
        if (BYPASS_EN && wb_v_q && (wb_dst_q == rt_addr)) begin
            rt_data = wb_d_q;
        end
        if (rt_addr == REG_ZERO) begin
            rt_data = '0;
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clock         (clock),
        .reset         (reset),
        .commit_v_i    (wb_v_q),
        .commit_idx_i  (wb_dst_q),
        .rs_addr_i     (rs_addr),
        .rt_addr_i     (rt_addr),
        .issue_valid_i (issue_valid),
        .issue_wr_i    (issue_wr),
        .issue_dest_i  (issue_dest),
        .stall_o       (stall),
        .busy_o        (busy)
    );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb; expectations follow REG_FILE_WB_BYPASS_EN.
module tb_reg_file_wb;

    logic        clock;
    logic        reset;
    logic [3:0]  Dest;
    logic        RegWrite;
    logic [15:0] wb_data;
    logic [3:0]  rs_addr;
    logic [3:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        issue_valid;
    logic        issue_wr;
    logic [3:0]  issue_dest;
    logic        stall;
    logic [15:0] busy;

    int unsigned checks;
    int unsigned passed;

`ifdef REG_FILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_wb #(
        .NREGS (16),
        .DW    (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .Dest        (Dest),
        .RegWrite    (RegWrite),
        .wb_data     (wb_data),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .issue_valid (issue_valid),
        .issue_wr    (issue_wr),
        .issue_dest  (issue_dest),
        .stall       (stall),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        checks      = 0;
        passed      = 0;
        reset       = 1'b1;
        Dest        = 4'd0;
        RegWrite    = 1'b0;
        wb_data     = 16'h0000;
        rs_addr     = 4'd0;
        rt_addr     = 4'd0;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_dest  = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state: every index reads zero, no busy, no stall.
        for (int i = 0; i < 16; i++) begin
            rs_addr = i[3:0];
            rt_addr = 4'(15 - i);
            #1;
            chk("reset_rs", {16'h0, rs_data}, 32'h0);
            chk("reset_rt", {16'h0, rt_data}, 32'h0);
        end
        chk("reset_busy", {16'h0, busy}, 32'h0);
        rs_addr     = 4'd3;
        rt_addr     = 4'd4;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = 4'd3;
        #1;
        chk("reset_stall", {31'h0, stall}, 32'h0);
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_dest  = 4'd0;
        tick();

        // Write BEEF to R5 at edge N.
        Dest     = 4'd5;
        RegWrite = 1'b1;
        wb_data  = 16'hBEEF;
        tick();
        RegWrite = 1'b0;
        wb_data  = 16'h0000;
        rs_addr  = 4'd5;
        rt_addr  = 4'd5;
        #1;
        chk("r5_cycleN_rs", {16'h0, rs_data}, BYP ? 32'hBEEF : 32'h0);
        chk("r5_cycleN_rt", {16'h0, rt_data}, BYP ? 32'hBEEF : 32'h0);
        tick();
        chk("r5_cycleN1_rs", {16'h0, rs_data}, 32'hBEEF);
        tick();
        chk("r5_cycleN2_rt", {16'h0, rt_data}, 32'hBEEF);

        // Write to R0 is dropped; issue to R0 never sets busy[0].
        Dest     = 4'd0;
        RegWrite = 1'b1;
        wb_data  = 16'hFFFF;
        tick();
        RegWrite = 1'b0;
        rs_addr  = 4'd0;
        rt_addr  = 4'd0;
        #1;
        chk("r0_after_capture", {16'h0, rs_data}, 32'h0);
        tick();
        chk("r0_after_commit", {16'h0, rt_data}, 32'h0);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = 4'd0;
        tick();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        #1;
        chk("busy0_never", {16'h0, busy}, 32'h0);

        // RAW stall on R3 until its writeback commits.
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = 4'd3;
        rs_addr     = 4'd0;
        rt_addr     = 4'd0;
        #1;
        chk("issue3_accept", {31'h0, stall}, 32'h0);
        tick();
        issue_wr   = 1'b0;
        issue_dest = 4'd0;
        rs_addr    = 4'd3;
        Dest       = 4'd3;
        RegWrite   = 1'b1;
        wb_data    = 16'h0333;
        #1;
        chk("busy3_set", {16'h0, busy}, 32'h0008);
        chk("raw_stall_c1", {31'h0, stall}, 32'h1);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("raw_stall_c2", {31'h0, stall}, BYP ? 32'h0 : 32'h1);
        chk("r3_pending", {16'h0, rs_data}, BYP ? 32'h0333 : 32'h0);
        tick();
        chk("raw_stall_c3", {31'h0, stall}, 32'h0);
        chk("busy3_clear", {16'h0, busy}, 32'h0);
        chk("r3_committed", {16'h0, rs_data}, 32'h0333);
        issue_valid = 1'b0;
        rs_addr     = 4'd0;
        tick();

        // Same-edge commit and accepted issue on R7: set wins.
        Dest     = 4'd7;
        RegWrite = 1'b1;
        wb_data  = 16'h7777;
        tick();
        RegWrite    = 1'b0;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = 4'd7;
        #1;
        chk("issue7_accept", {31'h0, stall}, 32'h0);
        tick();
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        rs_addr     = 4'd7;
        #1;
        chk("busy7_set_wins", {16'h0, busy}, 32'h0080);
        chk("r7_committed", {16'h0, rs_data}, 32'h7777);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        rs_addr     = 4'd0;
        #1;
        chk("waw_stall", {31'h0, stall}, 32'h1);
        Dest     = 4'd7;
        RegWrite = 1'b1;
        wb_data  = 16'h7A7A;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("waw_not_bypassed", {31'h0, stall}, 32'h1);
        tick();
        chk("waw_released", {31'h0, stall}, 32'h0);
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        #1;
        chk("busy7_clear", {16'h0, busy}, 32'h0);
        rs_addr = 4'd7;
        #1;
        chk("r7_second", {16'h0, rs_data}, 32'h7A7A);

        // Reset while R9 writeback is pending: discarded, busy cleared.
        Dest        = 4'd9;
        RegWrite    = 1'b1;
        wb_data     = 16'h1234;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dest  = 4'd9;
        tick();
        RegWrite    = 1'b0;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        rs_addr     = 4'd9;
        rt_addr     = 4'd5;
        #1;
        chk("busy9_set", {16'h0, busy}, 32'h0200);
        chk("r9_pending", {16'h0, rs_data}, BYP ? 32'h1234 : 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("r9_after_reset", {16'h0, rs_data}, 32'h0);
        chk("busy_after_reset", {16'h0, busy}, 32'h0);
        chk("r5_after_reset", {16'h0, rt_data}, 32'h0);
        tick();
        chk("r9_not_committed", {16'h0, rs_data}, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
